// File: rtl/alu_muldiv.sv
// Sequential multiply/divide unit: one radix-2 step per clock, result returned as two beats.
// Multiply gives the low then high product word; divide gives the quotient then the remainder.
module alu_muldiv #(
  parameter int DATA_WL = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic               op,
  input  logic               signd,
  input  logic [DATA_WL-1:0] a_in,
  input  logic [DATA_WL-1:0] b_in,
  output logic               busy,
  output logic [DATA_WL-1:0] p_out,
  output logic               valid,
  output logic               hi,
  output logic               z_flag,
  output logic               s_flag,
  output logic               dz_flag
);
  localparam int W      = DATA_WL;
  localparam int CNT_WL = $clog2(DATA_WL) + 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT_LO, OUT_HI} state_t;

  state_t            state_q, state_d;
  logic [CNT_WL-1:0] cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [2*W:0]      acc_q, acc_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      araw_q, araw_d;
  logic [W-1:0]      phi_q, phi_d;
  logic [W-1:0]      pout_q, pout_d;
  logic              valid_q, valid_d;
  logic              hi_q, hi_d;
  logic              z_q, z_d;
  logic              s_q, s_d;
  logic              dz_q, dz_d;

  logic [W:0]        mul_sum;
  logic [W:0]        div_r;
  logic [W:0]        div_diff;
  logic              div_ge;
  logic [W-1:0]      div_rem;
  logic [W-1:0]      a_mag;
  logic [W-1:0]      b_mag;
  logic [2*W:0]      step;
  logic [2*W-1:0]    prod_s;
  logic [W-1:0]      quo_s;
  logic [W-1:0]      rem_s;

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide), plus sign fix-up.
  always_comb begin
    a_mag    = (signd && a_in[W-1]) ? -a_in : a_in;
    b_mag    = (signd && b_in[W-1]) ? -b_in : b_in;
    mul_sum  = acc_q[2*W:W] + (acc_q[0] ? {1'b0, b_q} : '0);
    div_r    = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_r - {1'b0, b_q};
    div_ge   = ~div_diff[W];
    div_rem  = div_ge ? div_diff[W-1:0] : div_r[W-1:0];
    if (op_q) begin
      step = {1'b0, div_rem, acc_q[W-2:0], div_ge};
    end else begin
      step = {1'b0, mul_sum, acc_q[W-1:1]};
    end
    prod_s = qneg_q ? -step[2*W-1:0] : step[2*W-1:0];
    quo_s  = qneg_q ? -step[W-1:0] : step[W-1:0];
    rem_s  = rneg_q ? -step[2*W-1:W] : step[2*W-1:W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    b_d     = b_q;
    araw_d  = araw_q;
    phi_d   = phi_q;
    pout_d  = pout_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    z_d     = z_q;
    s_d     = s_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (ld) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          qneg_d  = signd & (a_in[W-1] ^ b_in[W-1]);
          rneg_d  = signd & a_in[W-1];
          acc_d   = {{(W+1){1'b0}}, a_mag};
          b_d     = b_mag;
          araw_d  = a_in;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_WL'(1);
        if (cnt_q == CNT_WL'(DATA_WL - 1)) begin
          state_d = OUT_LO;
          valid_d = 1'b1;
          hi_d    = 1'b0;
          dz_d    = 1'b0;
          if (!op_q) begin
            pout_d = prod_s[W-1:0];
            phi_d  = prod_s[2*W-1:W];
            z_d    = (step[2*W-1:0] == '0);
            s_d    = qneg_q && (step[2*W-1:0] != '0);
          end else if (b_q == '0) begin
            // Divide by zero still runs the full latency; the dividend is echoed unmodified.
            pout_d = '1;
            phi_d  = araw_q;
            z_d    = 1'b0;
            s_d    = 1'b0;
            dz_d   = 1'b1;
          end else begin
            pout_d = quo_s;
            phi_d  = rem_s;
            z_d    = (step[W-1:0] == '0);
            s_d    = qneg_q && (step[W-1:0] != '0);
          end
        end
      end
      OUT_LO: begin
        state_d = OUT_HI;
        pout_d  = phi_q;
        hi_d    = 1'b1;
      end
      OUT_HI: begin
        state_d = IDLE;
        pout_d  = '0;
        valid_d = 1'b0;
        hi_d    = 1'b0;
        z_d     = 1'b0;
        s_d     = 1'b0;
        dz_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      araw_q  <= '0;
      phi_q   <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
      z_q     <= 1'b0;
      s_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      araw_q  <= araw_d;
      phi_q   <= phi_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      z_q     <= z_d;
      s_q     <= s_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign p_out   = pout_q;
  assign valid   = valid_q;
  assign hi      = hi_q;
  assign z_flag  = z_q;
  assign s_flag  = s_q;
  assign dz_flag = dz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (DATA_WL=16): directed corner cases, random operations
// against an integer-arithmetic reference model, ld-while-busy and reset-abort scenarios.
module tb_alu_muldiv;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         ld;
  logic         op;
  logic         signd;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic [W-1:0] p_out;
  logic         valid;
  logic         hi;
  logic         z_flag;
  logic         s_flag;
  logic         dz_flag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          lat;
    logic [15:0] p0;
    logic [15:0] p1;
    logic        h0;
    logic        h1;
    logic        v1;
    logic [2:0]  f0;
    logic [2:0]  f1;
    logic        busyEnd;
    logic        validEnd;
  } obs_t;

  typedef struct {
    logic        op;
    logic        sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [2:0]  ef;
  } vec_t;

  alu_muldiv #(.DATA_WL(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .op     (op),
    .signd  (signd),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .p_out  (p_out),
    .valid  (valid),
    .hi     (hi),
    .z_flag (z_flag),
    .s_flag (s_flag),
    .dz_flag(dz_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: plain integer arithmetic; flags packed as {z, s, dz}.
  function automatic void model(input logic opV, input logic sgV, input logic [15:0] aV,
                                input logic [15:0] bV, output logic [15:0] e0,
                                output logic [15:0] e1, output logic [2:0] ef);
    longint av;
    longint bv;
    longint p;
    longint q;
    longint r;
    av = sgV ? longint'($signed(aV)) : longint'(aV);
    bv = sgV ? longint'($signed(bV)) : longint'(bV);
    if (!opV) begin
      p  = av * bv;
      e0 = p[15:0];
      e1 = p[31:16];
      ef = {p == 0, p < 0, 1'b0};
    end else if (bV == 16'h0000) begin
      e0 = 16'hFFFF;
      e1 = aV;
      ef = 3'b001;
    end else begin
      q  = av / bv;
      r  = av % bv;
      e0 = q[15:0];
      e1 = r[15:0];
      ef = {q == 0, q < 0, 1'b0};
    end
  endfunction

  // Issues one operation (ld captured at the next edge) and records both beats and the end state.
  task automatic applyStimulus(input logic opV, input logic sgV, input logic [15:0] aV,
                               input logic [15:0] bV, output obs_t o);
    ld = 1'b1; op = opV; signd = sgV; a_in = aV; b_in = bV;
    @(posedge clk); #1;
    ld = 1'b0;
    o.lat = 0;
    while (valid !== 1'b1 && o.lat < 40) begin
      @(posedge clk); #1;
      o.lat++;
    end
    o.p0 = p_out; o.h0 = hi; o.f0 = {z_flag, s_flag, dz_flag};
    @(posedge clk); #1;
    o.p1 = p_out; o.h1 = hi; o.v1 = valid; o.f1 = {z_flag, s_flag, dz_flag};
    @(posedge clk); #1;
    o.busyEnd = busy; o.validEnd = valid;
  endtask

  task automatic test_reset();
    ld = 1'b1; op = 1'b1; signd = 1'b1; a_in = 16'h1234; b_in = 16'h0003;
    @(posedge clk); #1;
    ld = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset valid: got %b expected 0", valid); end
    total++; if (hi !== 1'b0) begin bad++; $display("[TB] FAIL reset hi: got %b expected 0", hi); end
    total++; if (p_out !== 16'h0000) begin bad++; $display("[TB] FAIL reset p_out: got %h expected 0000", p_out); end
    total++;
    if ({z_flag, s_flag, dz_flag} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset flags: got %b expected 000", {z_flag, s_flag, dz_flag});
    end
  endtask

  task automatic test_directed();
    vec_t v[13];
    obs_t o;
    v[0]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 3'b000};
    v[1]  = '{1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 3'b010};
    v[2]  = '{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 3'b010};
    v[3]  = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 3'b000};
    v[4]  = '{1'b1, 1'b0, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 3'b001};
    v[5]  = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 3'b100};
    v[6]  = '{1'b1, 1'b1, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 3'b001};
    v[7]  = '{1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 3'b000};
    v[8]  = '{1'b1, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 3'b010};
    v[9]  = '{1'b1, 1'b1, 16'hFFFA, 16'h0003, 16'hFFFE, 16'h0000, 3'b010};
    v[10] = '{1'b1, 1'b0, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 3'b100};
    v[11] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3'b100};
    v[12] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 3'b010};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(v[i].op, v[i].sg, v[i].a, v[i].b, o);
      total++; if (o.lat !== 16) begin bad++; $display("[TB] FAIL directed[%0d] latency: got %0d expected 16", i, o.lat); end
      total++; if (o.p0 !== v[i].e0 || o.h0 !== 1'b0) begin
        bad++; $display("[TB] FAIL directed[%0d] beat0: got %h hi=%b expected %h hi=0", i, o.p0, o.h0, v[i].e0);
      end
      total++; if (o.p1 !== v[i].e1 || {o.h1, o.v1} !== 2'b11) begin
        bad++; $display("[TB] FAIL directed[%0d] beat1: got %h hi=%b valid=%b expected %h hi=1 valid=1", i, o.p1, o.h1, o.v1, v[i].e1);
      end
      total++; if (o.f0 !== v[i].ef) begin bad++; $display("[TB] FAIL directed[%0d] flags0: got %b expected %b", i, o.f0, v[i].ef); end
      total++; if (o.f1 !== v[i].ef) begin bad++; $display("[TB] FAIL directed[%0d] flags1: got %b expected %b", i, o.f1, v[i].ef); end
      total++; if ({o.busyEnd, o.validEnd} !== 2'b00) begin
        bad++; $display("[TB] FAIL directed[%0d] end: got busy=%b valid=%b expected 0 0", i, o.busyEnd, o.validEnd);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic opV, sgV;
    logic [15:0] aV, bV, e0, e1;
    logic [2:0] ef;
    int sel;
    for (int i = 0; i < 40; i++) begin
      opV = 1'($urandom_range(0, 1));
      sgV = 1'($urandom_range(0, 1));
      aV  = 16'($urandom);
      bV  = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) bV = 16'h0000;
      else if (sel == 1) bV = 16'hFFFF;
      else if (sel == 2) aV = 16'h8000;
      else if (sel == 3) bV = 16'($urandom_range(1, 7));
      model(opV, sgV, aV, bV, e0, e1, ef);
      applyStimulus(opV, sgV, aV, bV, o);
      total++; if (o.lat !== 16) begin bad++; $display("[TB] FAIL random[%0d] latency: got %0d expected 16", i, o.lat); end
      total++; if (o.p0 !== e0 || o.p1 !== e1) begin
        bad++; $display("[TB] FAIL random[%0d] op=%b sg=%b a=%h b=%h beats: got %h %h expected %h %h", i, opV, sgV, aV, bV, o.p0, o.p1, e0, e1);
      end
      total++; if (o.f0 !== ef || o.f1 !== ef) begin
        bad++; $display("[TB] FAIL random[%0d] flags: got %b %b expected %b", i, o.f0, o.f1, ef);
      end
      total++; if ({o.h0, o.h1, o.v1, o.busyEnd} !== 4'b0110) begin
        bad++; $display("[TB] FAIL random[%0d] handshake: got %b expected 0110", i, {o.h0, o.h1, o.v1, o.busyEnd});
      end
    end
  endtask

  task automatic test_ld_ignored();
    logic [15:0] e0, e1, b0, b1;
    logic [2:0] ef;
    int nBeats, firstCyc, dirty, lateBusy;
    nBeats = 0; firstCyc = -1; dirty = 0; lateBusy = 0; b0 = '0; b1 = '0;
    model(1'b0, 1'b0, 16'h1234, 16'h0011, e0, e1, ef);
    ld = 1'b1; op = 1'b0; signd = 1'b0; a_in = 16'h1234; b_in = 16'h0011;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      op = 1'b1; signd = 1'b1; a_in = 16'hFFFF; b_in = 16'h0003;
      ld = (cyc <= 18);
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        nBeats++;
        if (nBeats == 1) begin firstCyc = cyc; b0 = p_out; end
        else b1 = p_out;
      end else if ({p_out, hi, z_flag, s_flag, dz_flag} !== '0) begin
        dirty++;
      end
      if (cyc >= 18 && busy !== 1'b0) lateBusy++;
    end
    ld = 1'b0;
    total++; if (nBeats !== 2) begin bad++; $display("[TB] FAIL ldbusy beat count: got %0d expected 2", nBeats); end
    total++; if (firstCyc !== 16) begin bad++; $display("[TB] FAIL ldbusy first beat cycle: got %0d expected 16", firstCyc); end
    total++; if (b0 !== e0 || b1 !== e1) begin
      bad++; $display("[TB] FAIL ldbusy beats: got %h %h expected %h %h", b0, b1, e0, e1);
    end
    total++; if (dirty !== 0) begin bad++; $display("[TB] FAIL ldbusy outputs nonzero while invalid: got %0d cycles expected 0", dirty); end
    total++; if (lateBusy !== 0) begin bad++; $display("[TB] FAIL ldbusy late capture: got %0d busy cycles expected 0", lateBusy); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [15:0] e0, e1;
    logic [2:0] ef;
    logic [15:0] aV, bV;
    for (int i = 0; i < 4; i++) begin
      aV = 16'($urandom);
      bV = 16'($urandom_range(1, 16'hFFFF));
      model(i[0], i[1], aV, bV, e0, e1, ef);
      applyStimulus(i[0], i[1], aV, bV, o);
      total++; if (o.lat !== 16 || o.p0 !== e0 || o.p1 !== e1) begin
        bad++; $display("[TB] FAIL b2b[%0d] result: got lat=%0d %h %h expected lat=16 %h %h", i, o.lat, o.p0, o.p1, e0, e1);
      end
    end
  endtask

  task automatic test_reset_abort();
    obs_t o;
    logic [15:0] e0, e1;
    logic [2:0] ef;
    int strayValid, strayBusy;
    strayValid = 0; strayBusy = 0;
    ld = 1'b1; op = 1'b1; signd = 1'b1; a_in = 16'hFFF9; b_in = 16'h0002;
    @(posedge clk); #1;
    ld = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, valid} !== 2'b00) begin
      bad++; $display("[TB] FAIL abort at T0+5: got busy=%b valid=%b expected 0 0", busy, valid);
    end
    ld = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset over ld: got busy=%b expected 0", busy); end
    ld = 1'b0; reset = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) strayValid++;
      if (busy !== 1'b0) strayBusy++;
    end
    total++; if (strayValid !== 0 || strayBusy !== 0) begin
      bad++; $display("[TB] FAIL abort stray activity: got valid=%0d busy=%0d cycles expected 0 0", strayValid, strayBusy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model(1'b0, 1'b1, 16'h8000, 16'h7FFF, e0, e1, ef);
    applyStimulus(1'b0, 1'b1, 16'h8000, 16'h7FFF, o);
    total++; if (o.lat !== 16 || o.p0 !== e0 || o.p1 !== e1 || o.f0 !== ef) begin
      bad++; $display("[TB] FAIL ld after reset: got lat=%0d %h %h %b expected lat=16 %h %h %b", o.lat, o.p0, o.p1, o.f0, e0, e1, ef);
    end
  endtask

  initial begin
    reset = 1'b1; ld = 1'b0; op = 1'b0; signd = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_directed();
    test_random();
    test_ld_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
